// File: rtl/zhq.sv
// zhq: sequential 8-bit binary to 3-digit BCD converter (double dabble),
// one input bit per clock with a start/busy/done handshake.
//
// Ports:
//   clk     in   1  clock, rising edge
//   rst_n   in   1  synchronous active-low reset
//   start   in   1  conversion request, honoured only while busy=0
//   DataIn  in   8  unsigned value, captured on the accepting edge
//   bai     out  4  hundreds digit (0..2)
//   shi     out  4  tens digit (0..9)
//   ge      out  4  units digit (0..9)
//   busy    out  1  conversion in progress
//   done    out  1  one-cycle pulse, digits updated on the same edge
module zhq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] DataIn,
  output logic [3:0] bai,
  output logic [3:0] shi,
  output logic [3:0] ge,
  output logic       busy,
  output logic       done
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t      state, state_next;
  logic [19:0] work, work_next;     // {bcd[11:0], bin[7:0]}
  logic [2:0]  cnt, cnt_next;
  logic [11:0] digits, digits_next; // {bai, shi, ge}
  logic        done_next;
  logic [19:0] adjusted;
  logic [19:0] shifted;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // All three nibbles are corrected from their pre-shift values in parallel,
  // then the whole register moves left one bit.
  always_comb begin
    adjusted        = work;
    adjusted[19:16] = add3(work[19:16]);
    adjusted[15:12] = add3(work[15:12]);
    adjusted[11:8]  = add3(work[11:8]);
    shifted         = {adjusted[18:0], 1'b0};
  end

  always_comb begin
    state_next  = state;
    work_next   = work;
    cnt_next    = cnt;
    digits_next = digits;
    done_next   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          work_next  = {12'h000, DataIn};
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        work_next = shifted;
        cnt_next  = cnt + 3'd1;
        if (cnt == 3'd7) begin
          digits_next = shifted[19:8];
          done_next   = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      work   <= '0;
      cnt    <= '0;
      digits <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      work   <= work_next;
      cnt    <= cnt_next;
      digits <= digits_next;
      done   <= done_next;
    end
  end

  assign busy = (state == SHIFT);
  assign bai  = digits[11:8];
  assign shi  = digits[7:4];
  assign ge   = digits[3:0];

endmodule

// File: tb/tb_zhq.sv
// Testbench for zhq: scenario tasks driving conversions, with expected BCD
// digits queued at each accepted start and popped when done is seen.
module tb_zhq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] DataIn;
  logic [3:0] bai;
  logic [3:0] shi;
  logic [3:0] ge;
  logic       busy;
  logic       done;

  int checks;
  int errors;
  int done_pulses;

  logic [11:0] exp_q[$];

  zhq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .DataIn (DataIn),
    .bai    (bai),
    .shi    (shi),
    .ge     (ge),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_pulses++;

  function automatic logic [11:0] model(input logic [7:0] v);
    int unsigned x;
    logic [3:0] h, t, u;
    x = v;
    h = 4'(x / 100);
    t = 4'((x / 10) % 10);
    u = 4'(x % 10);
    return {h, t, u};
  endfunction

  // Present a start with value v for one edge and queue its expected result.
  // Returns at the negedge right after the accepting edge.
  task automatic accept(input logic [7:0] v);
    @(negedge clk);
    start  = 1'b1;
    DataIn = v;
    exp_q.push_back(model(v));
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Wait (bounded) for done; lat counts negedges since the accept edge.
  task automatic wait_done(output int lat, output bit seen);
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    seen = done;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; DataIn = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({bai, shi, ge, busy, done} !== 14'b0) begin
      errors++;
      $display("FAIL reset_state: got %h/%h/%h busy=%b done=%b, want 0/0/0 busy=0 done=0", bai, shi, ge, busy, done);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({bai, shi, ge, busy, done} !== 14'b0) begin
      errors++;
      $display("FAIL idle_state: got %h/%h/%h busy=%b done=%b, want 0/0/0 busy=0 done=0", bai, shi, ge, busy, done);
    end
  endtask

  // Single conversion with full checking of latency, result and pulse width.
  task automatic convert_check(input string name, input logic [7:0] v);
    int lat;
    bit seen;
    logic [11:0] exp;
    accept(v);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy: got busy=%b, want 1", name, busy);
    end
    wait_done(lat, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: no done within 20 cycles, want done at 8", name);
      void'(exp_q.pop_front());
      return;
    end
    exp = exp_q.pop_front();
    if (lat !== 8) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles, want 8", name, lat);
    end
    checks++;
    if ({bai, shi, ge} !== exp || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_result: in=%0d got %0d/%0d/%0d busy=%b, want %0d/%0d/%0d busy=0",
               name, v, bai, shi, ge, busy, exp[11:8], exp[7:4], exp[3:0]);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || {bai, shi, ge} !== exp) begin
      errors++;
      $display("FAIL %s_hold: got done=%b %0d/%0d/%0d, want done=0 %0d/%0d/%0d",
               name, done, bai, shi, ge, exp[11:8], exp[7:4], exp[3:0]);
    end
  endtask

  task automatic test_sequence;
    logic [7:0] vals[4] = '{8'h6A, 8'h2B, 8'h03, 8'h25};
    foreach (vals[i]) convert_check($sformatf("seq%0d", i), vals[i]);
  endtask

  task automatic test_boundaries;
    logic [7:0] vals[4] = '{8'h00, 8'hFF, 8'h63, 8'h64};
    foreach (vals[i]) convert_check($sformatf("bound%0d", i), vals[i]);
  endtask

  // start held and DataIn disturbed while busy; only the captured value counts.
  task automatic test_busy_ignore;
    int lat;
    int pulses0;
    bit seen;
    logic [11:0] exp;
    pulses0 = done_pulses;
    accept(8'hC8);
    start  = 1'b1;
    DataIn = 8'h11;
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 7) start = 1'b0;
    end
    seen = done;
    start = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (!seen || lat !== 8 || {bai, shi, ge} !== exp) begin
      errors++;
      $display("FAIL busy_ignore_result: seen=%b lat=%0d got %0d/%0d/%0d, want lat=8 %0d/%0d/%0d",
               seen, lat, bai, shi, ge, exp[11:8], exp[7:4], exp[3:0]);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (done_pulses - pulses0 !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore_extra: got %0d done pulses busy=%b, want 1 busy=0", done_pulses - pulses0, busy);
    end
  endtask

  // start held high: next accept at E9, using DataIn present at that edge.
  task automatic test_back_to_back;
    int lat;
    bit seen;
    logic [11:0] exp;
    @(negedge clk);
    start  = 1'b1;
    DataIn = 8'h7B;
    exp_q.push_back(model(8'h7B));
    @(negedge clk);
    wait_done(lat, seen);
    exp = exp_q.pop_front();
    checks++;
    if (!seen || lat !== 8 || {bai, shi, ge} !== exp) begin
      errors++;
      $display("FAIL b2b_first: seen=%b lat=%0d got %0d/%0d/%0d, want lat=8 %0d/%0d/%0d",
               seen, lat, bai, shi, ge, exp[11:8], exp[7:4], exp[3:0]);
    end
    DataIn = 8'hD2;
    exp_q.push_back(model(8'hD2));
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: got busy=%b after done, want 0", busy);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_reaccept: got busy=%b one cycle after done, want 1", busy);
    end
    wait_done(lat, seen);
    exp = exp_q.pop_front();
    checks++;
    if (!seen || lat !== 8 || {bai, shi, ge} !== exp) begin
      errors++;
      $display("FAIL b2b_second: seen=%b lat=%0d got %0d/%0d/%0d, want lat=8 %0d/%0d/%0d",
               seen, lat, bai, shi, ge, exp[11:8], exp[7:4], exp[3:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    int pulses0;
    accept(8'hFF);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    void'(exp_q.pop_front());
    pulses0 = done_pulses;
    @(negedge clk);
    checks++;
    if ({bai, shi, ge, busy, done} !== 14'b0) begin
      errors++;
      $display("FAIL abort_state: got %h/%h/%h busy=%b done=%b, want 0/0/0 busy=0 done=0", bai, shi, ge, busy, done);
    end
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (done_pulses !== pulses0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done pulses busy=%b, want 0 busy=0", done_pulses - pulses0, busy);
    end
    convert_check("after_abort", 8'h2B);
  endtask

  task automatic test_sweep;
    int lat;
    bit seen;
    int bad;
    logic [11:0] exp;
    bad = 0;
    for (int v = 0; v < 256; v++) begin
      accept(8'(v));
      wait_done(lat, seen);
      exp = exp_q.pop_front();
      checks++;
      if (!seen || lat !== 8 || {bai, shi, ge} !== exp || bai > 4'd2 || shi > 4'd9 || ge > 4'd9) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL sweep_%0d: seen=%b lat=%0d got %0d/%0d/%0d, want lat=8 %0d/%0d/%0d",
                   v, seen, lat, bai, shi, ge, exp[11:8], exp[7:4], exp[3:0]);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL sweep_width_%0d: done=%b one cycle after pulse, want 0", v, done);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    done_pulses = 0;
    test_reset;
    test_sequence;
    test_boundaries;
    test_busy_ignore;
    test_back_to_back;
    test_reset_abort;
    test_sweep;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/zhq.md
# zhq

Sequential 8-bit binary to 3-digit BCD converter. It splits an unsigned byte into hundreds, tens and units digits for seven-segment or decimal display logic downstream. The conversion uses iterative shift-and-add-3 (double dabble), one bit per clock, with a start/busy/done handshake. The last result is held at the outputs until the next conversion completes.

## Interface
- No parameters; widths are fixed (8-bit input, three 4-bit BCD digits).
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  request a conversion of `DataIn`; honoured only when `busy`=0.
- `DataIn`  in  8  unsigned binary value 0..255; sampled only on an accepted start edge.
- `bai`  out  4  hundreds digit, BCD, range 0..2.
- `shi`  out  4  tens digit, BCD, range 0..9.
- `ge`  out  4  units digit, BCD, range 0..9.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle pulse; outputs updated on the same edge.

## Operation
- Internal state: IDLE / SHIFT, 20-bit work register {bcd[11:0], bin[7:0]}, 3-bit bit counter.
- IDLE: on edge with `start`=1, the block:
  - loads the work register with {12'h000, DataIn};
  - clears the counter;
  - sets `busy`=1;
  - moves to SHIFT.
- SHIFT, each edge:
  - for each of the three BCD nibbles, if the value is ≥5, add 3 (adjustments use pre-shift values, all nibbles in parallel);
  - shift the whole 20-bit register left by 1;
  - increment the counter.
- On the 8th SHIFT edge (counter = 7), the block:
  - loads `bai`/`shi`/`ge` from the post-shift bcd[11:8]/[7:4]/[3:0];
  - pulses `done`=1;
  - clears `busy`;
  - returns to IDLE.
- `start` while `busy`=1 is ignored and not queued. `DataIn` changes after acceptance have no effect on the running conversion.
- Result identity: `bai`*100 + `shi`*10 + `ge` = captured DataIn. `bai` ≤ 2; unused high bits of `bai` are always 0.
- Outputs hold their value between conversions. `done` is low except for its single pulse cycle.

## Timing
- Reset (edge with `rst_n`=0): `bai`=`shi`=`ge`=0, `busy`=0, `done`=0, state IDLE, work register and counter cleared.
- Reset mid-conversion aborts it; no `done` is produced. Reset overrides `start` on the same edge.
- Latency: accept edge E0, result and `done` visible after edge E8 (8 cycles). `busy` is high from after E0 through E8.
- Back-to-back conversions:
  - `start` sampled at E8 is ignored, since `busy` is still 1 at that edge.
  - Earliest next accept is E9, giving 9 cycles per conversion.
- `start` held continuously high: the block converts repeatedly, one accept every 9 cycles, each using the `DataIn` value present at its accept edge.

## Test plan
- Reset, then idle with `start`=0 → `bai`/`shi`/`ge`=0/0/0, `busy`=0, `done`=0.
- Sequence 0x6A, 0x2B, 0x03, 0x25, each with one start pulse, waiting for `done` between them:
  - 0x6A → 1/0/6;
  - 0x2B → 0/4/3;
  - 0x03 → 0/0/3;
  - 0x25 → 0/3/7;
  - `done` exactly 8 cycles after each accept.
- Boundaries: 0x00 → 0/0/0; 0xFF → 2/5/5; 0x63 (99) → 0/9/9; 0x64 (100) → 1/0/0.
- `start`=1 and `DataIn` changed to 0x11 while `busy`: result is still for the originally captured value; no extra `done`.
- Assert `rst_n`=0 at E4 of a 0xFF conversion: outputs go to 0, `busy`=0, no `done`. A new start with 0x2B afterwards → 0/4/3.
- Exhaustive sweep 0..255: each result matches value/100, (value/10)%10, value%10. Every digit ≤9, `done` width is exactly 1 cycle.
